// File: rtl/ahb_lite_mem_slave_if.sv
// ahb_lite_mem_slave_if: AHB-Lite bus signals between a master and the memory slave
interface ahb_lite_mem_slave_if;
    logic        hsel_i;
    logic [31:0] haddr_i;
    logic [1:0]  htrans_i;
    logic [2:0]  hsize_i;
    logic [2:0]  hburst_i;
    logic [3:0]  hprot_i;
    logic        hmastlock_i;
    logic        hwrite_i;
    logic [31:0] hwdata_i;
    logic        hready_i;
    logic        hready_o;
    logic        hresp_o;
    logic [31:0] hrdata_o;
    modport slave (
        input  hsel_i, haddr_i, htrans_i, hsize_i, hburst_i, hprot_i, hmastlock_i,
               hwrite_i, hwdata_i, hready_i,
        output hready_o, hresp_o, hrdata_o
    );
    modport master (
        output hsel_i, haddr_i, htrans_i, hsize_i, hburst_i, hprot_i, hmastlock_i,
               hwrite_i, hwdata_i, hready_i,
        input  hready_o, hresp_o, hrdata_o
    );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: AHB-Lite word memory with wait states, two-cycle ERROR and a sim-done mailbox
module ahb_lite_mem_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] DONE_ADDR   = 32'h4000_0000
) (
    input  logic                       hclk,
    input  logic                       hreset,
    ahb_lite_mem_slave_if.slave        bus,
    output logic                       sim_done_o,
    output logic [31:0]                xfer_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ERR1 = 2'd2, ERR2 = 2'd3;
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    logic [31:0]   mem [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          active_q, active_d;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q, size_q;
    logic          write_q, done_q, sim_done_q;
    logic [31:0]   count_q;
    logic          can_acc, acc, bad, ok_acc, bad_acc, complete;
    logic [3:0]    be;
    logic [31:0]   mask;
    logic          unused_ok;

    assign unused_ok = ^{bus.hburst_i, bus.hprot_i, bus.hmastlock_i, bus.htrans_i[0]};

    // Address-phase decode: only IDLE and ERR2 end a data phase, so only they can accept
    always_comb begin
        can_acc = state_q == IDLE || state_q == ERR2;
        acc     = can_acc && bus.hsel_i && bus.hready_i && bus.htrans_i[1];
        bad     = bus.hsize_i > 3'd2
               || (bus.hsize_i == 3'd1 && bus.haddr_i[0])
               || (bus.hsize_i == 3'd2 && bus.haddr_i[1:0] != 2'd0)
               || (bus.haddr_i[31:AW+2] != BASE_ADDR[31:AW+2] && bus.haddr_i != DONE_ADDR);
        ok_acc  = acc && !bad;
        bad_acc = acc && bad;
        // an OKAY data phase completes in IDLE; WAIT always hands back to IDLE for the last cycle
        complete = active_q && state_q == IDLE;
        be   = size_q == 2'd0 ? 4'b0001 << off_q : size_q == 2'd1 ? 4'b0011 << off_q : 4'b1111;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    end

    // Next state, wait counter and data-phase-pending flag
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = can_acc ? ok_acc : active_q;
        if (can_acc) begin
            state_d = bad_acc ? ERR1 : (ok_acc && WAIT_STATES > 0) ? WAIT : IDLE;
            cnt_d   = ok_acc ? WS_LAST : 4'd0;
        end else if (state_q == WAIT) begin
            state_d = cnt_q == 4'd0 ? IDLE : WAIT;
            cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        end else if (state_q == ERR1) begin
            state_d = ERR2;
        end
    end

    // Control and status registers; memory itself is outside the reset domain
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            active_q   <= 1'b0;
            idx_q      <= '0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
            sim_done_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            if (ok_acc) begin
                idx_q   <= bus.haddr_i[AW+1:2];
                off_q   <= bus.haddr_i[1:0];
                size_q  <= bus.hsize_i[1:0];
                write_q <= bus.hwrite_i;
                done_q  <= bus.haddr_i == DONE_ADDR;
            end
            if (complete)
                count_q <= count_q + 32'd1;
            if (complete && write_q && done_q && size_q == 2'd2 && bus.hwdata_i == 32'h0000_000D)
                sim_done_q <= 1'b1;
        end
    end

    // Byte-lane merge of write data into the addressed word at data-phase completion
    always_ff @(posedge hclk) begin
        if (complete && write_q && !done_q)
            mem[idx_q] <= (mem[idx_q] & ~mask) | (bus.hwdata_i & mask);
    end

    assign bus.hready_o = state_q != WAIT && state_q != ERR1;
    assign bus.hresp_o  = state_q == ERR1 || state_q == ERR2;
    assign bus.hrdata_o = (complete && !write_q && !done_q) ? mem[idx_q] : 32'h0;
    assign sim_done_o   = sim_done_q;
    assign xfer_count_o = count_q;
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// tb_ahb_lite_mem_slave: vector table plus randomized traffic against a byte-level memory model
module tb_ahb_lite_mem_slave;
    localparam logic [31:0] DONE = 32'h4000_0000;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        use_exp;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 0, hreset = 1;
    logic d = 0, hold = 0;
    logic hsel = 0, hwrite = 0, hmastlock = 0;
    logic [1:0] htrans = 0;
    logic [2:0] hsize = 0, hburst = 0;
    logic [3:0] hprot = 4'h3;
    logic [31:0] haddr = 0, hwdata = 0;
    logic done0, done3;
    logic [31:0] cnt0, cnt3;

    int n_chk = 0, n_fail = 0;
    vec_t tv[$];
    logic [31:0] mem_m [2][1024];
    logic [31:0] cnt_m [2];
    logic        done_m [2];

    ahb_lite_mem_slave_if b0();
    ahb_lite_mem_slave_if b3();

    assign b0.hsel_i = hsel && !d;
    assign b3.hsel_i = hsel && d;
    assign b0.haddr_i = haddr;        assign b3.haddr_i = haddr;
    assign b0.htrans_i = htrans;      assign b3.htrans_i = htrans;
    assign b0.hsize_i = hsize;        assign b3.hsize_i = hsize;
    assign b0.hburst_i = hburst;      assign b3.hburst_i = hburst;
    assign b0.hprot_i = hprot;        assign b3.hprot_i = hprot;
    assign b0.hmastlock_i = hmastlock; assign b3.hmastlock_i = hmastlock;
    assign b0.hwrite_i = hwrite;      assign b3.hwrite_i = hwrite;
    assign b0.hwdata_i = hwdata;      assign b3.hwdata_i = hwdata;
    assign b0.hready_i = b0.hready_o && !hold;
    assign b3.hready_i = b3.hready_o && !hold;

    ahb_lite_mem_slave #(.WAIT_STATES(0)) u0 (
        .hclk(clk), .hreset(hreset), .bus(b0), .sim_done_o(done0), .xfer_count_o(cnt0));
    ahb_lite_mem_slave #(.WAIT_STATES(3)) u3 (
        .hclk(clk), .hreset(hreset), .bus(b3), .sim_done_o(done3), .xfer_count_o(cnt3));

    wire        rdy   = d ? b3.hready_o : b0.hready_o;
    wire        rsp   = d ? b3.hresp_o : b0.hresp_o;
    wire [31:0] rdat  = d ? b3.hrdata_o : b0.hrdata_o;
    wire [31:0] cnt_a = d ? cnt3 : cnt0;
    wire        don_a = d ? done3 : done0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t dut=%0d)", nm, act, exp, $time, d);
        end
    endtask

    function automatic vec_t mk(logic sel, logic [1:0] tr, logic wr, logic [2:0] sz,
                                logic [31:0] a, logic [31:0] wd, logic ue, logic er, logic [31:0] erd);
        vec_t v;
        v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd;
        v.use_exp = ue; v.exp_resp = er; v.exp_rdata = erd;
        return v;
    endfunction

    function automatic logic m_bad(vec_t v);
        int unsigned nb;
        if (!(v.sel && v.trans[1])) return 1'b0;
        if (v.size > 3'd2) return 1'b1;
        nb = 1 << v.size;
        if (v.addr % nb != 0) return 1'b1;
        return !(v.addr < 4 * 1024) && v.addr != DONE;
    endfunction

    task automatic finish_dp(input int dp, input int waits, input logic r_rsp, input logic [31:0] r_rd);
        vec_t v;
        logic act, bad, ok;
        logic [31:0] er;
        int ew, lane;
        v   = tv[dp];
        act = v.sel && v.trans[1];
        bad = m_bad(v);
        ok  = act && !bad;
        er  = (ok && !v.wr && v.addr < 4096) ? mem_m[d][v.addr / 4] : 32'h0;
        ew  = !act ? 0 : bad ? 1 : (d ? 3 : 0);
        chk("waits", 32'(waits), 32'(ew));
        chk("resp", {31'b0, r_rsp}, {31'b0, v.use_exp ? v.exp_resp : bad});
        chk("rdata", r_rd, v.use_exp ? v.exp_rdata : er);
        chk("count", cnt_a, cnt_m[d]);
        chk("sim_done", {31'b0, don_a}, {31'b0, done_m[d]});
        if (ok) begin
            cnt_m[d] = cnt_m[d] + 1;
            if (v.wr && v.addr == DONE) begin
                if (v.size == 3'd2 && v.wdata == 32'hD) done_m[d] = 1'b1;
            end else if (v.wr) begin
                for (int b = 0; b < (1 << v.size); b++) begin
                    lane = int'(v.addr % 4) + b;
                    mem_m[d][v.addr / 4][8*lane +: 8] = v.wdata[8*lane +: 8];
                end
            end
        end
    endtask

    // Pipelined master: address phase of entry i overlaps data phase of entry i-1
    task automatic run_seq();
        int i = 0, dp = -1, waits = 0, guard = 0;
        int lim = 20 * tv.size() + 50;
        logic r, s;
        logic [31:0] rd;
        while (i < tv.size() || dp >= 0) begin
            if (i < tv.size()) begin
                hsel = tv[i].sel; htrans = tv[i].trans; hwrite = tv[i].wr;
                hsize = tv[i].size; haddr = tv[i].addr;
            end else begin
                hsel = 0; htrans = 0;
            end
            hwdata = dp >= 0 ? tv[dp].wdata : 32'h0;
            @(negedge clk);
            r = rdy; s = rsp; rd = rdat;
            if (dp >= 0) begin
                if (!r) begin
                    waits++;
                    chk("stall_resp", {31'b0, s}, {31'b0, m_bad(tv[dp])});
                    chk("stall_rdata", rd, 32'h0);
                end else begin
                    finish_dp(dp, waits, s, rd);
                    waits = 0;
                end
            end
            guard++;
            if (guard > lim) begin
                chk("timeout", 32'(guard), 32'(lim));
                break;
            end
            @(posedge clk); #1;
            if (r) begin
                dp = i < tv.size() ? i : -1;
                if (i < tv.size()) i++;
            end
        end
        tv.delete();
    endtask

    task automatic preload();
        logic [7:0] ib;
        for (int i = 0; i < 64; i++) begin
            ib = 8'(i);
            tv.push_back(mk(1, 2, 1, 2, 32'(i * 4), {ib, ~ib, 8'h5A, ib}, 0, 0, 0));
        end
        run_seq();
    endtask

    task automatic rand_seq(input int n);
        vec_t v;
        int k;
        for (int j = 0; j < n; j++) begin
            k = $urandom_range(0, 19);
            v.sel   = $urandom_range(0, 9) != 0;
            v.trans = k < 14 ? {1'b1, 1'($urandom_range(0, 1))} : 2'($urandom_range(0, 3));
            v.wr    = 1'($urandom_range(0, 1));
            v.size  = k == 17 ? 3'd3 : 3'($urandom_range(0, 2));
            v.addr  = k == 18 ? 32'h1000 + 32'(4 * $urandom_range(0, 15)) :
                      k == 19 ? DONE : 32'($urandom_range(0, 255));
            if (k != 16 && v.size <= 3'd2) v.addr = v.addr & ~((32'd1 << v.size) - 1);
            v.wdata = $urandom;
            v.use_exp = 0; v.exp_resp = 0; v.exp_rdata = 0;
            tv.push_back(v);
        end
        hburst = 3'($urandom_range(0, 7));
        run_seq();
    endtask

    initial begin
        cnt_m[0] = 0; cnt_m[1] = 0; done_m[0] = 0; done_m[1] = 0;
        #2;
        chk("rst_hready", {31'b0, rdy}, 32'd1);
        chk("rst_hresp", {31'b0, rsp}, 32'd0);
        chk("rst_hrdata", rdat, 32'h0);
        chk("rst_count", cnt0, 32'h0);
        chk("rst_done", {31'b0, done0}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        hreset = 0;

        // WAIT_STATES=0: back-to-back write/read of the same word
        d = 0;
        tv.push_back(mk(1, 2, 1, 2, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0));
        tv.push_back(mk(1, 2, 0, 2, 32'h10, 32'h0, 1, 0, 32'hDEADBEEF));
        run_seq();
        chk("count_after_wr_rd", cnt0, 32'd2);
        preload();

        // byte/half merges over known words
        tv.push_back(mk(1, 2, 1, 2, 32'h10, 32'h11223344, 1, 0, 32'h0));
        tv.push_back(mk(1, 2, 1, 0, 32'h13, 32'hAA000000, 1, 0, 32'h0));
        tv.push_back(mk(1, 2, 0, 2, 32'h10, 32'h0, 1, 0, 32'hAA223344));
        tv.push_back(mk(1, 2, 1, 1, 32'h16, 32'hBEEF0000, 1, 0, 32'h0));
        tv.push_back(mk(1, 2, 0, 2, 32'h14, 32'h0, 1, 0, 32'hBEEF5A05));
        run_seq();

        // error responses leave memory and count alone
        tv.push_back(mk(1, 2, 0, 2, 32'h1000, 32'h0, 1, 1, 32'h0));
        tv.push_back(mk(1, 2, 1, 1, 32'h01, 32'hFFFFFFFF, 1, 1, 32'h0));
        tv.push_back(mk(1, 2, 0, 3, 32'h20, 32'h0, 1, 1, 32'h0));
        tv.push_back(mk(1, 2, 0, 2, 32'h10, 32'h0, 1, 0, 32'hAA223344));
        tv.push_back(mk(1, 2, 0, 2, 32'h00, 32'h0, 1, 0, 32'h00FF5A00));
        run_seq();
        chk("count_after_errors", cnt0, 32'd73);

        // mailbox: wrong value, idle/deselected cycles, then the done value
        tv.push_back(mk(1, 2, 1, 2, DONE, 32'h0E, 1, 0, 32'h0));
        run_seq();
        chk("done_wrong_value", {31'b0, done0}, 32'd0);
        tv.push_back(mk(1, 0, 0, 2, 32'h10, 32'h0, 1, 0, 32'h0));
        tv.push_back(mk(0, 2, 1, 2, 32'h10, 32'h0BAD0BAD, 1, 0, 32'h0));
        tv.push_back(mk(1, 2, 1, 2, DONE, 32'h0D, 1, 0, 32'h0));
        tv.push_back(mk(1, 2, 0, 2, DONE, 32'h0, 1, 0, 32'h0));
        tv.push_back(mk(1, 2, 0, 2, 32'h10, 32'h0, 1, 0, 32'hAA223344));
        run_seq();
        chk("done_set", {31'b0, done0}, 32'd1);

        // no capture while hready_i is low
        hold = 1; hsel = 1; htrans = 2; hwrite = 1; hsize = 2; haddr = 32'h10;
        @(posedge clk); #1;
        hold = 0; hsel = 0; htrans = 0; hwdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("hold_no_wait", {31'b0, rdy}, 32'd1);
        @(posedge clk); #1;
        chk("hold_count", cnt0, cnt_m[0]);
        tv.push_back(mk(1, 2, 0, 2, 32'h10, 32'h0, 1, 0, 32'hAA223344));
        run_seq();

        rand_seq(80);
        chk("done_sticky", {31'b0, done0}, 32'd1);

        // WAIT_STATES=3: INCR4 read of preloaded words
        d = 1;
        preload();
        hburst = 3'b011;
        tv.push_back(mk(1, 2, 0, 2, 32'h20, 32'h0, 1, 0, 32'h08F75A08));
        tv.push_back(mk(1, 3, 0, 2, 32'h24, 32'h0, 1, 0, 32'h09F65A09));
        tv.push_back(mk(1, 3, 0, 2, 32'h28, 32'h0, 1, 0, 32'h0AF55A0A));
        tv.push_back(mk(1, 3, 0, 2, 32'h2C, 32'h0, 1, 0, 32'h0BF45A0B));
        tv.push_back(mk(1, 2, 1, 2, 32'h40, 32'h5555AAAA, 1, 0, 32'h0));
        tv.push_back(mk(1, 2, 0, 2, 32'h40, 32'h0, 1, 0, 32'h5555AAAA));
        run_seq();

        // reset in the middle of a write stall
        hsel = 1; htrans = 2; hwrite = 1; hsize = 2; haddr = 32'h40;
        @(posedge clk); #1;
        hsel = 0; htrans = 0; hwdata = 32'h12345678;
        @(negedge clk);
        chk("stall_before_reset", {31'b0, rdy}, 32'd0);
        #2 hreset = 1;
        #1;
        chk("mid_rst_hready", {31'b0, rdy}, 32'd1);
        chk("mid_rst_hresp", {31'b0, rsp}, 32'd0);
        chk("mid_rst_hrdata", rdat, 32'h0);
        chk("mid_rst_count3", cnt3, 32'h0);
        chk("mid_rst_count0", cnt0, 32'h0);
        chk("mid_rst_done0", {31'b0, done0}, 32'd0);
        cnt_m[0] = 0; cnt_m[1] = 0; done_m[0] = 0; done_m[1] = 0;
        @(posedge clk); #1;
        hreset = 0;
        tv.push_back(mk(1, 2, 0, 2, 32'h40, 32'h0, 1, 0, 32'h5555AAAA));
        run_seq();
        chk("count_after_reset", cnt3, 32'd1);

        rand_seq(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ahb_lite_mem_slave.md
AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 Parameter DEPTH, default 1024: memory size in 32-bit words; a power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte base of the memory window; aligned to 4*DEPTH.
REQ-003 Parameter WAIT_STATES, default 0: range 0..15; number of hready_o-low cycles inserted per OKAY data phase.
REQ-004 Parameter DONE_ADDR, default 32'h4000_0000: end-of-simulation mailbox byte address.
REQ-005 hclk  in  1  bus clock; all state updates on its rising edge.
REQ-006 hreset  in  1  asynchronous, active-high reset.
REQ-007 hsel_i  in  1  slave select.
REQ-008 haddr_i  in  32  address-phase byte address.
REQ-009 htrans_i  in  2  transfer type: IDLE 0, BUSY 1, NONSEQ 2, SEQ 3.
REQ-010 hsize_i  in  3  transfer size: BYTE 0, HALF_WORD 1, WORD 2.
REQ-011 hburst_i, hprot_i, hmastlock_i  in  3/4/1  accepted but functionally ignored.
REQ-012 hwrite_i  in  1  1 = write, 0 = read.
REQ-013 hwdata_i  in  32  write data, valid in the data phase.
REQ-014 hready_i  in  1  bus-level ready, previous transfer complete.
REQ-015 hready_o  out  1  slave ready, ends the data phase.
REQ-016 hresp_o  out  1  0 = OKAY, 1 = ERROR.
REQ-017 hrdata_o  out  32  read data.
REQ-018 sim_done_o  out  1  sticky end-of-simulation flag.
REQ-019 xfer_count_o  out  32  count of completed OKAY NONSEQ/SEQ transfers.

Function
REQ-020 A transfer shall be accepted on a rising edge where hsel_i=1, hready_i=1 and htrans_i[1]=1; the block shall register the address, size and direction for the data phase.
REQ-021 An IDLE or BUSY transfer, or one with hsel_i=0, shall get a zero-wait OKAY data phase (hready_o=1, hresp_o=0) with no side effects.
REQ-022 The block shall implement states IDLE, WAIT, ERR1 and ERR2.
- IDLE -> WAIT: OKAY transfer accepted and WAIT_STATES>0.
- IDLE -> ERR1: erroneous transfer accepted.
- WAIT -> IDLE: wait counter expires.
- ERR1 -> ERR2: always.
- ERR2 -> IDLE, or ERR2 -> ERR1 if another erroneous transfer is accepted.
REQ-023 A transfer shall be erroneous when:
- hsize_i > WORD; or
- haddr_i is misaligned for hsize_i; or
- haddr_i is outside [BASE_ADDR, BASE_ADDR+4*DEPTH) and is not DONE_ADDR.
REQ-024 An ERROR response shall take two cycles:
- ERR1: hready_o=0, hresp_o=1.
- ERR2: hready_o=1, hresp_o=1.
- No memory write and no count increment shall occur.
REQ-025 In WAIT, hready_o shall be 0 for exactly WAIT_STATES cycles with hresp_o=0; the completing cycle shall have hready_o=1.
REQ-026 A write shall commit on the edge that ends its data phase (hready_o=1). It shall use hwdata_i, little-endian byte lanes selected by the registered size and haddr[1:0]; unselected bytes stay unchanged.
REQ-027 For a read, hrdata_o shall equal mem[word index] while hready_o=1 in that data phase, and 32'h0 in all other cycles.
REQ-028 A read whose data phase directly follows a write data phase to the same word shall return the newly written data.
REQ-029 A WORD write of 32'h0000_000D to DONE_ADDR shall set sim_done_o on its completing edge and respond OKAY; any other access to DONE_ADDR shall respond OKAY with no effect, and reads return 0.
REQ-030 xfer_count_o shall increment by 1 on each OKAY NONSEQ/SEQ completion and wrap from 32'hFFFF_FFFF to 0.
REQ-031 While hready_i=0, no new address phase shall be captured, regardless of hsel_i and htrans_i.

Reset
REQ-032 While hreset=1, independent of hclk, the outputs shall be hready_o=1, hresp_o=0, hrdata_o=0, sim_done_o=0 and xfer_count_o=0. State shall be IDLE and the wait counter 0.
REQ-033 Reset asserted mid-transfer shall abort the transfer, with no memory write; memory contents shall not be cleared by reset.
REQ-034 The first transfer shall be accepted on the first rising edge after hreset deasserts.

Verification
REQ-035 WAIT_STATES=0: WORD write 32'hDEADBEEF to 0x10, then read 0x10 back-to-back -> hrdata_o=32'hDEADBEEF, zero waits, xfer_count_o=2.
REQ-036 WAIT_STATES=3: INCR4 read from 0x20 -> each beat shows 3 hready_o-low cycles and then data; the address bus holds during the stalls.
REQ-037 BYTE write 8'hAA to 0x13 over a word preloaded with 32'h11223344, then WORD read -> 32'hAA223344.
REQ-038 Read of BASE_ADDR+4*DEPTH, then HALF_WORD access to 0x01 -> each gets a two-cycle ERROR (0/1 then 1/1); memory and xfer_count_o unchanged.
REQ-039 WORD write 32'h0D to 0x4000_0000 -> sim_done_o=1 after the completing edge and stays 1; a write of 32'h0E does not set it.
REQ-040 hreset pulsed during a WAIT_STATES=3 write stall -> outputs return to reset values immediately, and the target word is unchanged on readback.
